wb_release: RTL

- Writeback end of the register locking loop. Registers are locked at operand fetch; this block collects results from the NXU execution units and drives the write-port/unlock side of the register bank and lock table.
- Each cycle it grants one result with a round-robin arbiter and registers it.
- Next cycle it issues one write-enable plus a lock-release pulse.
- A result whose tag is stale (squashed by a taken branch) is not written, but its register lock is still released.

---
 rtl/wb_release_pkg.sv | 17 +
 rtl/wb_release_rr_arbiter.sv | 35 +++
 rtl/wb_release.sv | 119 +++++++++++
 3 files changed

// File: rtl/wb_release_pkg.sv
// Shared types and constants for the writeback/release stage.
package wb_release_pkg;

  localparam int unsigned WB_NXU      = 4;
  localparam int unsigned WB_TAGW     = 4;
  // Tags narrower than this are zero-extended into the result record.
  localparam int unsigned WB_TAGW_MAX = 8;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0]             regD;
    logic [31:0]            data;
    logic [WB_TAGW_MAX-1:0] tag;
  } wb_result_t;

endpackage

// File: rtl/wb_release_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic          found;
  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      // Explicit wrap keeps the index below N for non-power-of-two N.
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      cand = sum[IW-1:0];
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/wb_release.sv
// Writeback end of the register locking loop: arbitrates XU results, issues write + lock release.
// Optional retire/squash counters are built when WB_RETIRE_CNT_EN is defined.
module wb_release
  import wb_release_pkg::*;
#(
  parameter int unsigned NXU  = WB_NXU,
  parameter int unsigned TAGW = WB_TAGW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NXU-1:0]    res_valid,
  output logic [NXU-1:0]    res_ready,
  input  logic [NXU*5-1:0]  res_regD,
  input  logic [NXU*32-1:0] res_data,
  input  logic [NXU*TAGW-1:0] res_tag,
  input  logic [TAGW-1:0]   tag_cur,
  output logic              we,
  output logic              rel,
  output logic [4:0]        regD,
  output logic [31:0]       in
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]       retire_cnt
`endif
);

  localparam int unsigned IW = $clog2(NXU);

  logic [NXU-1:0] gnt;
  logic [IW-1:0]  gnt_idx;
  logic           gnt_any;
  logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
  wb_result_t     sel;
  logic [WB_TAGW_MAX-1:0] tag_cur_ext;

  logic        we_q, we_d;
  logic        rel_q, rel_d;
  logic [4:0]  regd_q, regd_d;
  logic [31:0] data_q, data_d;

  rr_arbiter #(.N(NXU)) u_arb (
    .req (res_valid),
    .ptr (rr_ptr_q),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign gnt_any     = |gnt;
  assign res_ready   = reset ? gnt : '0;
  assign tag_cur_ext = WB_TAGW_MAX'(tag_cur);

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NXU; i++) begin
      if (gnt[i]) begin
        sel.regD = res_regD[i*5 +: 5];
        sel.data = res_data[i*32 +: 32];
        sel.tag  = WB_TAGW_MAX'(res_tag[i*TAGW +: TAGW]);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_any) rr_ptr_d = (gnt_idx == IW'(NXU-1)) ? '0 : gnt_idx + 1'b1;
    rel_d  = gnt_any;
    we_d   = gnt_any && (sel.tag == tag_cur_ext) && (sel.regD != REG_ZERO);
    regd_d = gnt_any ? sel.regD : regd_q;
    data_d = gnt_any ? sel.data : data_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= '0;
      we_q     <= 1'b0;
      rel_q    <= 1'b0;
      regd_q   <= '0;
      data_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      we_q     <= we_d;
      rel_q    <= rel_d;
      regd_q   <= regd_d;
      data_q   <= data_d;
    end
  end

  assign we   = we_q;
  assign rel  = rel_q;
  assign regD = regd_q;
  assign in   = data_q;

  // A register is relocked only after its release; accepting it again right on top of it means a double lock.
  a_single_outstanding : assert property (@(posedge clk) disable iff (!reset)
    !(gnt_any && sel.regD != REG_ZERO && rel_q && sel.regD == regd_q));

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt_q, retire_cnt_d;
  logic [31:0] squash_cnt_q, squash_cnt_d;

  always_comb begin
    retire_cnt_d = retire_cnt_q + {31'd0, we_q};
    squash_cnt_d = squash_cnt_q + {31'd0, rel_q & ~we_q};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retire_cnt_q <= '0;
      squash_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule
